// File: rtl/round_sequencer.sv
// Labyrinth round controller: one-second time base, decaying score and a
// valid/ack handshake for the final result. Define HISCORE_EN to keep the best goal score.
module round_sequencer #(
  parameter int          TICK_DIV   = 100000000,
  parameter int unsigned PENALTY    = 65,
  parameter logic [15:0] SCORE_INIT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pause_tgl,
  input  logic        goal,
  input  logic        result_ack,
  output logic [1:0]  state,
  output logic        tick,
  output logic [15:0] score,
  output logic [15:0] elapsed,
  output logic        result_valid,
  output logic [15:0] final_score,
  output logic        timeout,
  output logic [15:0] hiscore
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          wrap;
  logic [16:0]   diff;
  logic [15:0]   dec_score;
  logic          to_zero;
  logic          goal_end;
  logic          restart;

  // A borrow out of the 17-bit subtraction means the score would go negative.
  always_comb begin
    wrap      = (state == S_RUN) && (div_cnt == DW'(TICK_DIV - 1));
    diff      = {1'b0, score} - 17'(PENALTY);
    dec_score = diff[16] ? 16'd0 : diff[15:0];
    to_zero   = wrap && (dec_score == 16'd0);
    goal_end  = goal && ((state == S_RUN) || (state == S_PAUSE));
    restart   = start && ((state == S_IDLE) ||
                          ((state == S_DONE) && (!result_valid || result_ack)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      tick         <= 1'b0;
      score        <= SCORE_INIT;
      elapsed      <= '0;
      result_valid <= 1'b0;
      final_score  <= '0;
      timeout      <= 1'b0;
      div_cnt      <= '0;
    end else begin
      tick <= 1'b0;
      if (restart) begin
        state        <= S_RUN;
        score        <= SCORE_INIT;
        elapsed      <= '0;
        div_cnt      <= '0;
        timeout      <= 1'b0;
        result_valid <= 1'b0;
      end else if (goal_end) begin
        // Goal wins over a coincident tick: the score is latched undecremented.
        state        <= S_DONE;
        final_score  <= score;
        timeout      <= 1'b0;
        result_valid <= 1'b1;
      end else begin
        case (state)
          S_RUN: begin
            if (wrap) begin
              div_cnt <= '0;
              score   <= dec_score;
              if (elapsed != 16'hFFFF) elapsed <= elapsed + 16'd1;
            end else begin
              div_cnt <= div_cnt + DW'(1);
            end
            // tick is only raised when the next cycle is still RUN.
            if (to_zero) begin
              state        <= S_DONE;
              final_score  <= 16'd0;
              timeout      <= 1'b1;
              result_valid <= 1'b1;
            end else if (pause_tgl) begin
              state <= S_PAUSE;
            end else begin
              tick <= wrap;
            end
          end
          S_PAUSE: begin
            if (pause_tgl) state <= S_RUN;
          end
          S_DONE: begin
            if (result_ack) result_valid <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef HISCORE_EN
  logic [15:0] hiscore_q;

  always_ff @(posedge clk) begin
    if (reset) hiscore_q <= '0;
    else if (goal_end && (score > hiscore_q)) hiscore_q <= score;
  end

  assign hiscore = hiscore_q;
`else
  assign hiscore = 16'd0;
`endif

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
- Controls one Labyrinth game round: start, run, pause and end.
- Owns the once-per-second time base and the decrementing score: SCORE_INIT minus PENALTY per elapsed second, saturating at 0.
- Latches the final result and hands it to the display/UART consumer with a valid/ack handshake.
- Sits between the button/accelerometer game logic (start, pause, goal) and the seven-segment/OLED score display.

Parameters:
- TICK_DIV, 100000000: clk cycles per one-second tick (100 MHz board clock).
- PENALTY, 65: score decrement per tick.
- SCORE_INIT, 16'hFFFF: score loaded at round start.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high; clock clk
- start  input  1  one-cycle pulse; begins a new round
- pause_tgl  input  1  one-cycle pulse; toggles RUN/PAUSE
- goal  input  1  one-cycle pulse; ball reached exit
- result_ack  input  1  consumer accepted result
- state  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
- tick  output  1  one-cycle pulse per counted second
- score  output  16  live score
- elapsed  output  16  seconds counted this round
- result_valid  output  1  final result available
- final_score  output  16  latched score at round end
- timeout  output  1  round ended by score reaching 0
- hiscore  output  16  best goal score since reset

Behaviour:
- Reset values: state=IDLE, tick=0, score=SCORE_INIT, elapsed=0, result_valid=0, final_score=0, timeout=0, hiscore=0. Divider count=0.
- Reset mid-round aborts the round immediately; nothing is latched.
- Divider width: $clog2(TICK_DIV). It counts only in RUN and holds its value in PAUSE.
  - When count==TICK_DIV-1: count<=0, tick<=1 for one cycle, elapsed<=elapsed+1 (saturates at 16'hFFFF), score<=max(score-PENALTY, 0).
  - The subtraction is done 17-bit wide; a borrow forces 0.
- IDLE: start -> RUN. On entry: score=SCORE_INIT, elapsed=0, divider=0, timeout=0. pause_tgl and goal are ignored.
- RUN:
  - Priority: goal > tick-to-zero > pause_tgl.
  - goal -> DONE with final_score<=current score (any tick in the same cycle is discarded) and timeout<=0.
  - A tick that makes score 0 -> DONE with final_score<=0 and timeout<=1.
  - pause_tgl -> PAUSE.
  - start in RUN is ignored.
- PAUSE:
  - score, elapsed and divider frozen; tick=0.
  - pause_tgl -> RUN; the divider resumes from its held value.
  - goal -> DONE as in RUN.
  - start is ignored.
- DONE:
  - result_valid=1 from the first DONE cycle until the cycle after result_ack is sampled high, then 0.
  - final_score and timeout stay stable while result_valid=1.
  - start is accepted only when result_valid=0 or result_ack=1 in the same cycle, and -> RUN with the same initialisation as IDLE->RUN.
  - A start that arrives while valid and un-acked is dropped.
- result_ack while result_valid=0 has no effect.
- tick is registered and never asserts outside RUN.

Optional Feature:
- Macro: HISCORE_EN.
- Defined: on the DONE-entry edge with timeout=0 and final_score>hiscore, hiscore<=final_score. hiscore is cleared only by reset.
- Undefined: no hiscore register; hiscore output is constant 0.

Test Plan:
- TICK_DIV=4, PENALTY=65, SCORE_INIT=65535; reset, start, run 12 cycles -> 3 tick pulses, elapsed=3, score=65340, state=RUN.
- Same config; pause_tgl after 1 tick, hold 20 cycles, pause_tgl again -> no tick, score=65470 while paused; next tick arrives at the held divider phase, not a fresh 4 cycles.
- SCORE_INIT=200; start, run -> score 135, 70, 5, then 0 -> state=DONE, timeout=1, final_score=0, result_valid=1, hiscore=0.
- goal and divider wrap in the same cycle with score=65470 -> final_score=65470, timeout=0, score not decremented; with HISCORE_EN, hiscore=65470.
- DONE with result_valid=1, no ack, start pulse -> remains DONE. Then result_ack=1 with start in the same cycle -> RUN, score=SCORE_INIT, elapsed=0, result_valid=0.
- reset asserted in PAUSE with elapsed=5 -> next cycle state=IDLE, score=SCORE_INIT, elapsed=0, result_valid=0, hiscore=0.
